// File: rtl/wb_cam_pkg.sv
// Shared constants for the camera-to-Wishbone DMA: capture FSM states and
// the layout of a buffered word (32-bit data plus 16-bit word index).
package wb_cam_pkg;

   localparam int DATA_W  = 32;
   localparam int IDX_W   = 16;
   localparam int ENTRY_W = DATA_W + IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_RUN      = 2'd2,
      ST_DRAIN    = 2'd3
   } cap_state_t;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } entry_t;

   // Word address from the frame base; the byte-offset bits of the base are dropped.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
      return (base & 32'hFFFF_FFFC) + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/wb_cam_dma_if.sv
// Wishbone classic write-master bus as seen by the camera DMA.
interface wb_cam_dma_if;

   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic        wb_ack_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_ack_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_ack_i
   );

endinterface

// File: rtl/wb_cam_fifo.sv
// Show-ahead word buffer between the pixel packer and the bus writer.
// Full/empty are registered from the count after this cycle's push/pop.
module wb_cam_fifo
   import wb_cam_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_push,
   input  entry_t i_entry,
   input  logic   i_pop,
   output entry_t o_head,
   output logic   o_full,
   output logic   o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]      r_count, w_count_next;
   logic               r_full, r_empty;
   logic               w_do_push, w_do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
   assign w_do_pop  = i_pop & ~r_empty;
   assign w_do_push = i_push & (~r_full | w_do_pop);

   always_comb begin
      w_count_next = r_count;
      unique case ({w_do_push, w_do_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= w_count_next;
         r_full  <= (w_count_next == CW'(DEPTH));
         r_empty <= (w_count_next == '0);
      end
   end

   assign o_head  = entry_t'(r_mem[r_rd_ptr]);
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/wb_cam_dma.sv
// Camera byte stream to Wishbone writes: packs 4 bytes per word little-endian,
// buffers word+index, and writes each word to base + 4*index.
module wb_cam_dma
   import wb_cam_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [31:0]  base_adr,
   input  logic [15:0]  word_cnt,
   input  logic         pix_valid,
   input  logic [7:0]   pix_data,
   input  logic         pix_sof,
   output logic         busy,
   output logic         done,
   output logic         overflow,
   wb_cam_dma_if.master wb
);

   cap_state_t  r_state, w_state_next;
   logic [31:0] r_base;
   logic [15:0] r_cnt, r_word_idx;
   logic [1:0]  r_byte_cnt;
   logic [23:0] r_word;
   logic        r_done, r_overflow, r_cyc;
   logic [31:0] r_adr, r_dat;
   logic        w_accept, w_take_sof, w_take_byte, w_push, w_finish;
   logic        w_pop, w_drop, w_full, w_empty;
   entry_t      w_push_entry, w_head;

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_take_sof   = 1'b0;
      w_take_byte  = 1'b0;
      w_push       = 1'b0;
      w_finish     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               if (word_cnt != 16'd0) w_state_next = ST_WAIT_SOF;
            end
         end
         ST_WAIT_SOF: begin
            if (pix_valid && pix_sof) begin
               w_take_sof   = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pix_valid) begin
               w_take_byte = 1'b1;
               if (r_byte_cnt == 2'd3) begin
                  w_push = 1'b1;
                  if (r_word_idx + 16'd1 == r_cnt) w_state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (w_empty && !r_cyc) begin
               w_finish     = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // The 4th byte goes straight into the buffer with the three already held.
   assign w_push_entry = '{idx: r_word_idx, data: {pix_data, r_word}};
   assign w_pop        = r_cyc & wb.wb_ack_i;
   assign w_drop       = w_push & w_full & ~w_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_base     <= '0;
         r_cnt      <= '0;
         r_word_idx <= '0;
         r_byte_cnt <= '0;
         r_word     <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_base     <= base_adr;
            r_cnt      <= word_cnt;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_done     <= (word_cnt == 16'd0);
            r_overflow <= 1'b0;
         end else if (w_finish) begin
            r_done <= 1'b1;
         end
         if (w_take_sof) begin
            r_word[7:0] <= pix_data;
            r_byte_cnt  <= 2'd1;
         end
         if (w_take_byte) begin
            unique case (r_byte_cnt)
               2'd0:    r_word[7:0]   <= pix_data;
               2'd1:    r_word[15:8]  <= pix_data;
               2'd2:    r_word[23:16] <= pix_data;
               default: r_word_idx    <= r_word_idx + 16'd1;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         // A dropped word still consumes its index, leaving a hole in memory.
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   wb_cam_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Entry stays buffered until acked; cyc drops for one cycle between writes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cyc <= 1'b0;
         r_adr <= '0;
         r_dat <= '0;
      end else if (r_cyc) begin
         if (wb.wb_ack_i) r_cyc <= 1'b0;
      end else if (!w_empty) begin
         r_cyc <= 1'b1;
         r_adr <= word_addr(r_base, w_head.idx);
         r_dat <= w_head.data;
      end
   end

   assign wb.wb_cyc_o = r_cyc;
   assign wb.wb_stb_o = r_cyc;
   assign wb.wb_we_o  = r_cyc;
   assign wb.wb_sel_o = r_cyc ? 4'hF : 4'h0;
   assign wb.wb_adr_o = r_adr;
   assign wb.wb_dat_o = r_dat;

   assign busy     = (r_state != ST_IDLE);
   assign done     = r_done;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_wb_cam_dma.sv
// Randomized and directed checks of wb_cam_dma against a frame-level model:
// bytes after SOF pack into words written at base + 4*i.
module tb_wb_cam_dma;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_adr;
   logic [15:0] word_cnt;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_sof;
   logic        busy, done, overflow;

   wb_cam_dma_if wb_if ();

   wb_cam_dma #(
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_adr  (base_adr),
      .word_cnt  (word_cnt),
      .pix_valid (pix_valid),
      .pix_data  (pix_data),
      .pix_sof   (pix_sof),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .wb        (wb_if)
   );

   always #5 clk = ~clk;

   int unsigned cycle_cnt = 0;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          ack_lat  = 0;
   bit          hold_ack = 1'b0;
   bit          stray    = 1'b0;
   bit          saw_cyc  = 1'b0;
   logic [31:0] cap_adr[$], cap_dat[$], exp_adr[$], exp_dat[$];
   logic [7:0]  byte_q[$];
   int unsigned stb_cyc_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Wishbone slave: acks after ack_lat wait states, checks the request is held steady.
   initial begin : slave
      int          wcnt;
      bit          in_wr;
      logic [31:0] a0, d0;
      wcnt = 0;
      in_wr = 1'b0;
      a0 = '0;
      d0 = '0;
      wb_if.wb_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         if (wb_if.wb_cyc_o) saw_cyc = 1'b1;
         if (wb_if.wb_ack_i) begin
            wb_if.wb_ack_i = 1'b0;
            in_wr = 1'b0;
            wcnt = 0;
         end else if (!wb_if.wb_stb_o) begin
            in_wr = 1'b0;
            wcnt = 0;
            if (stray && $urandom_range(0, 3) == 0) wb_if.wb_ack_i = 1'b1;
         end else begin
            if (!in_wr) begin
               in_wr = 1'b1;
               a0 = wb_if.wb_adr_o;
               d0 = wb_if.wb_dat_o;
               stb_cyc_q.push_back(cycle_cnt);
            end
            if (!hold_ack && wcnt >= ack_lat) begin
               check_eq("wr_adr_stable", wb_if.wb_adr_o, a0);
               check_eq("wr_dat_stable", wb_if.wb_dat_o, d0);
               check_eq("wr_we_cyc_sel", {26'd0, wb_if.wb_we_o, wb_if.wb_cyc_o, wb_if.wb_sel_o},
                        {26'd0, 1'b1, 1'b1, 4'hF});
               cap_adr.push_back(wb_if.wb_adr_o);
               cap_dat.push_back(wb_if.wb_dat_o);
               $display("wr adr=0x%08h dat=0x%08h t=%0d", wb_if.wb_adr_o, wb_if.wb_dat_o, cycle_cnt);
               wb_if.wb_ack_i = 1'b1;
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic drive(input logic [7:0] d, input logic s);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = s;
      @(negedge clk);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic idle_cycle();
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
      pix_sof   = 1'($urandom);
      @(negedge clk);
      pix_sof   = 1'b0;
   endtask

   task automatic start_frame(input logic [31:0] b, input logic [15:0] n);
      cap_adr.delete();
      cap_dat.delete();
      exp_adr.delete();
      exp_dat.delete();
      stb_cyc_q.delete();
      byte_q.delete();
      start    = 1'b1;
      base_adr = b;
      word_cnt = n;
      @(negedge clk);
      start    = 1'b0;
      base_adr = $urandom;
      word_cnt = 16'($urandom);
   endtask

   // Garbage before SOF, then n_bytes bytes starting at SOF; optional stray SOFs and a start while busy.
   task automatic stream(input int n_pre, input int n_bytes, input int gap_pct, input bit mess);
      logic [7:0] b;
      logic       s;
      for (int i = 0; i < n_pre; i++) drive(8'($urandom), 1'b0);
      for (int i = 0; i < n_bytes; i++) begin
         if ($urandom_range(0, 99) < gap_pct) idle_cycle();
         if ($urandom_range(0, 99) < gap_pct) idle_cycle();
         b = 8'($urandom);
         s = (i == 0) ? 1'b1 : (mess && $urandom_range(0, 5) == 0);
         byte_q.push_back(b);
         if (mess && i == 5 && i < n_bytes - 4) begin
            start    = 1'b1;
            base_adr = $urandom;
            word_cnt = 16'($urandom_range(1, 9));
         end
         drive(b, s);
         start = 1'b0;
      end
   endtask

   task automatic build_model(input logic [31:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         exp_dat.push_back({byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]});
         exp_adr.push_back((b & 32'hFFFF_FFFC) + 32'(4 * i));
      end
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!(done === 1'b1 && busy === 1'b0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_eq("done_not_busy", {30'd0, done, busy}, 32'd2);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check_eq({tag, "_nwrites"}, cap_adr.size(), exp_adr.size());
      n = (cap_adr.size() < exp_adr.size()) ? cap_adr.size() : exp_adr.size();
      for (int i = 0; i < n; i++) begin
         check_eq({tag, "_adr"}, cap_adr[i], exp_adr[i]);
         check_eq({tag, "_dat"}, cap_dat[i], exp_dat[i]);
      end
      $display("frame %s writes=%0d expected=%0d", tag, cap_adr.size(), exp_adr.size());
   endtask

   initial begin : main
      int          c4;
      int          k;
      logic [31:0] b;
      int          n;

      reset = 1'b0;
      start = 1'b0;
      base_adr = '0;
      word_cnt = '0;
      pix_valid = 1'b0;
      pix_data = '0;
      pix_sof = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_status", {29'd0, done, busy, overflow}, 32'd0);
      check_eq("rst_bus", {25'd0, wb_if.wb_cyc_o, wb_if.wb_stb_o, wb_if.wb_we_o, wb_if.wb_sel_o}, 32'd0);
      check_eq("rst_adr", wb_if.wb_adr_o, 32'd0);
      check_eq("rst_dat", wb_if.wb_dat_o, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Zero-length frame: done on the next cycle, no bus activity.
      saw_cyc = 1'b0;
      start_frame(32'h0000_0800, 16'd0);
      check_eq("cnt0_done_busy", {30'd0, done, busy}, 32'd2);
      repeat (5) @(negedge clk);
      check_eq("cnt0_no_cyc", {31'd0, saw_cyc}, 32'd0);

      // Two words, one wait state, with first-write latency.
      ack_lat = 1;
      stray = 1'b0;
      start_frame(32'h0000_1000, 16'd2);
      check_eq("busy_after_start", {30'd0, done, busy}, 32'd1);
      drive(8'h01, 1'b1);
      drive(8'h02, 1'b0);
      drive(8'h03, 1'b0);
      c4 = cycle_cnt;
      drive(8'h04, 1'b0);
      drive(8'h05, 1'b0);
      drive(8'h06, 1'b0);
      drive(8'h07, 1'b0);
      drive(8'h08, 1'b0);
      wait_done(100);
      check_eq("first_stb_latency", (stb_cyc_q.size() > 0) ? stb_cyc_q[0] - c4 : 32'hFFFF_FFFF, 32'd2);
      exp_adr.push_back(32'h0000_1000);
      exp_dat.push_back(32'h0403_0201);
      exp_adr.push_back(32'h0000_1004);
      exp_dat.push_back(32'h0807_0605);
      compare_writes("two_words");

      // Bytes before SOF are not captured.
      ack_lat = 0;
      start_frame(32'h0000_2000, 16'd1);
      drive(8'hAA, 1'b0);
      drive(8'hBB, 1'b0);
      drive(8'h11, 1'b1);
      drive(8'h22, 1'b0);
      drive(8'h33, 1'b0);
      drive(8'h44, 1'b0);
      wait_done(100);
      exp_adr.push_back(32'h0000_2000);
      exp_dat.push_back(32'h4433_2211);
      compare_writes("pre_sof");

      // Randomized frames with stray acks, stray SOFs and a start while busy.
      for (int it = 0; it < 10; it++) begin
         b = (it == 0) ? 32'hFFFF_FFF6 : $urandom;
         n = $urandom_range(1, 6);
         ack_lat = $urandom_range(0, 2);
         stray = 1'b1;
         start_frame(b, 16'(n));
         stream($urandom_range(0, 3), n * 4 + 4, $urandom_range(0, 40), 1'b1);
         build_model(b, n);
         wait_done(400);
         check_eq("rand_overflow", {31'd0, overflow}, 32'd0);
         compare_writes("random");
      end
      stray = 1'b0;

      // Stalled bus: only the words that fit in the buffer are written.
      ack_lat = 0;
      hold_ack = 1'b1;
      b = 32'h0000_3000;
      start_frame(b, 16'd8);
      stream(0, 32, 0, 1'b0);
      repeat (200) @(negedge clk);
      check_eq("stall_overflow", {31'd0, overflow}, 32'd1);
      check_eq("stall_busy", {31'd0, busy}, 32'd1);
      check_eq("stall_no_writes", cap_adr.size(), 32'd0);
      hold_ack = 1'b0;
      build_model(b, DEPTH);
      wait_done(200);
      check_eq("stall_overflow_kept", {31'd0, overflow}, 32'd1);
      compare_writes("stall");

      start_frame(32'h0000_0900, 16'd0);
      check_eq("restart_clears_ovf", {29'd0, done, busy, overflow}, 32'd4);

      // Reset while a write awaits ack, then a clean frame.
      hold_ack = 1'b1;
      start_frame(32'h0000_4000, 16'd1);
      stream(0, 4, 0, 1'b0);
      k = 0;
      while (wb_if.wb_stb_o !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_eq("stb_before_reset", {31'd0, wb_if.wb_stb_o}, 32'd1);
      reset = 1'b0;
      #1;
      check_eq("reset_drops_cyc_stb", {30'd0, wb_if.wb_cyc_o, wb_if.wb_stb_o}, 32'd0);
      check_eq("reset_status", {29'd0, done, busy, overflow}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      hold_ack = 1'b0;
      @(negedge clk);
      b = 32'h0000_5000;
      start_frame(b, 16'd1);
      stream(1, 4, 20, 1'b0);
      build_model(b, 1);
      wait_done(100);
      compare_writes("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_cam_dma.md
WB_CAM_DMA -- requirements
Module: wb_cam_dma

Interface
REQ-001 The block SHALL have one parameter: FIFO_DEPTH, default 4, number of 48-bit entries (32 data + 16 word index) in the word buffer.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; arms one frame capture.
REQ-005 base_adr  input  32  byte address of word 0; bits [1:0] ignored.
REQ-006 word_cnt  input  16  number of 32-bit words to capture.
REQ-007 pix_valid  input  1  pix_data qualifier.
REQ-008 pix_data  input  8  pixel byte from camera capture.
REQ-009 pix_sof  input  1  marks the first byte of a frame, qualified by pix_valid.
REQ-010 busy  output  1  high from start acceptance until done.
REQ-011 done  output  1  sticky; set at completion, cleared by next accepted start.
REQ-012 overflow  output  1  sticky; set when a word is dropped, cleared by next accepted start.
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone classic master write strobes.
REQ-014 wb_adr_o  output  32  byte address; wb_sel_o  output  4; wb_dat_o  output  32.
REQ-015 wb_ack_i  input  1  slave acknowledge.

Function
REQ-016 Capture FSM SHALL have states IDLE, WAIT_SOF, RUN, DRAIN.
REQ-017 In IDLE, start SHALL latch base_adr/word_cnt, clear done/overflow, zero byte and word counters, set busy, go to WAIT_SOF; start while busy SHALL be ignored.
REQ-018 start with word_cnt==0 SHALL go directly to IDLE with done=1 one cycle later; no bus cycle issued.
REQ-019 WAIT_SOF SHALL ignore bytes until pix_valid&pix_sof; that byte SHALL be byte 0 of word 0 and FSM enters RUN.
REQ-020 In RUN, pix_sof SHALL be treated as an ordinary byte.
REQ-021 Packing SHALL be little-endian: byte k (0..3) into bits [8k+7:8k].
REQ-022 On the 4th byte the word and its index SHALL be pushed to the FIFO next cycle; the word index SHALL then increment.
REQ-023 If the FIFO is full at push, the word SHALL be dropped, overflow set, and the index still incremented (memory hole, later addresses stay correct).
REQ-024 When the index reaches word_cnt, further bytes SHALL be ignored and FSM enters DRAIN.
REQ-025 Bus side: when idle and FIFO non-empty, next cycle SHALL assert cyc=stb=we=1, sel=4'hF, adr=base+4*index (32-bit wrap), dat=entry data.
REQ-026 Strobes and address/data SHALL be held stable until wb_ack_i; on ack the entry SHALL be popped and cyc/stb deasserted the following cycle (minimum one idle cycle between writes).
REQ-027 Latency: 4th byte at cycle N -> stb high at cycle N+2 when FIFO empty and bus idle.
REQ-028 Push and pop in the same cycle SHALL both succeed; full/empty flags SHALL use the post-operation count.
REQ-029 DRAIN SHALL exit to IDLE, with busy=0 and done=1, in the cycle after the FIFO is empty and no write is outstanding.
REQ-030 wb_ack_i while stb is low SHALL be ignored.

Reset
REQ-031 While reset is low, all state SHALL clear asynchronously: FSM=IDLE, FIFO empty, counters 0, busy=done=overflow=0, cyc=stb=we=0, adr=dat=0, sel=0.
REQ-032 Reset asserted mid-write SHALL drop cyc/stb immediately; the partial frame SHALL be abandoned.

Structure
REQ-033 FSM state encodings and the 48-bit entry width SHALL be constants in a shared package wb_cam_pkg.
REQ-034 The word buffer SHALL be a separate sub-module wb_cam_fifo (synchronous, FIFO_DEPTH entries, full/empty outputs).

Verification
REQ-035 base=0x1000, cnt=2, SOF then bytes 01..08, ack after 1 wait -> writes 0x04030201@0x1000, 0x08070605@0x1004; done=1, busy=0.
REQ-036 Bytes before SOF (AA,BB) then SOF on 11,22,33,44, cnt=1 -> single write 0x44332211; AA/BB never written.
REQ-037 cnt=8, ack withheld 200 cycles, continuous bytes -> exactly FIFO_DEPTH words written in order; overflow=1; words 5..8 at base+16..28 minus dropped ones; done=1.
REQ-038 start with cnt=0 -> done=1 next cycle, no cyc asserted.
REQ-039 reset low while stb high awaiting ack -> cyc/stb=0 same cycle; after release, new start with cnt=1 completes normally.
REQ-040 Second start during busy and pix_sof mid-RUN -> both ignored; addresses and data unchanged from a clean run.
